// File: rtl/de1_input_conditioner.sv
// Per-channel synchroniser, debounce, polarity normalisation and edge pulses for DE1-SoC keys/switches.
// Optional hold-to-repeat on rise_pulse is enabled by defining DE1_INPUT_CONDITIONER_HOLD_REPEAT_EN.
module de1_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clock_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TERM     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    if (WIDTH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("de1_input_conditioner: illegal parameter value");
    end

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_q;
    logic [WIDTH-1:0] norm_s;

`ifdef DE1_INPUT_CONDITIONER_HOLD_REPEAT_EN
    localparam int            RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW     = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_PER  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]    rep_cnt_q [WIDTH];
    logic [RW-1:0]    rep_cnt_d [WIDTH];
    logic [WIDTH-1:0] rep_phase_q, rep_phase_d;
`endif

    // Inversion is applied after synchronisation so the chain only ever sees raw pin levels.
    assign norm_s = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

    // Synchroniser chain; reset parks it at the deasserted pin level.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {WIDTH{INACTIVE}};
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Debounce counters, accepted levels and edge pulses.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (norm_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == TERM) begin
                level_d[i] = norm_s[i];
                rise_d[i]  = norm_s[i];
                fall_d[i]  = ~norm_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
`ifdef DE1_INPUT_CONDITIONER_HOLD_REPEAT_EN
        // Repeat only while the level is and stays asserted, so it never collides with a fall.
        for (int i = 0; i < WIDTH; i++) begin
            rep_cnt_d[i]   = '0;
            rep_phase_d[i] = 1'b0;
            if (level_q[i] && level_d[i]) begin
                if (!rep_phase_q[i] && rep_cnt_q[i] == R_DLY) begin
                    rise_d[i]      = 1'b1;
                    rep_phase_d[i] = 1'b1;
                end else if (rep_phase_q[i] && rep_cnt_q[i] == R_PER) begin
                    rise_d[i]      = 1'b1;
                    rep_phase_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i]   = rep_cnt_q[i] + RW'(1);
                    rep_phase_d[i] = rep_phase_q[i];
                end
            end else begin
                rep_cnt_d[i]   = '0;
                rep_phase_d[i] = 1'b0;
            end
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= |(rise_d | fall_d);
        end
    end

`ifdef DE1_INPUT_CONDITIONER_HOLD_REPEAT_EN
    // Auto-repeat counters.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                rep_cnt_q[i] <= '0;
            end
            rep_phase_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
            rep_phase_q <= rep_phase_d;
        end
    end
`endif

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_q;

endmodule
